wprime_iter_ctrl: RTL

- Sequencer for the fixed-point ICA weight-update loop.
- Each iteration: latches w, starts the w' datapath (branch A = g, branch B = g'), joins both branch valids, fires the subtractor, then normalisation and the convergence check.
- Commits the new w and iterates until converged, MAX_ITER is reached, or a stage watchdog expires.
- Control only: no double data passes through it.

---
 rtl/ica_ctrl_pkg.sv | 14 +
 rtl/stage_watchdog.sv | 24 ++
 rtl/wprime_iter_ctrl.sv | 123 ++++++++++++
 3 files changed

// File: rtl/ica_ctrl_pkg.sv
// ica_ctrl_pkg: shared types and default constants for the ICA weight-update sequencer.
//   fp_double    : raw IEEE-754 double as carried by the surrounding datapath
//   ctrl_state_e : sequencer states
//   *_DEF        : default parameter values
package ica_ctrl_pkg;
  typedef logic [63:0] fp_double;
  typedef enum logic [3:0] {IDLE, LOAD, BR_RUN, SUB, NORM, CONV, COMMIT, DONE, ERR} ctrl_state_e;
  localparam int unsigned MAX_ITER_DEF = 64;
  localparam int unsigned TIMEOUT_DEF = 4096;
  localparam int unsigned ITER_W_DEF = 7;
  function automatic logic is_wait_state(input ctrl_state_e s);
    return s inside {BR_RUN, NORM, CONV};
  endfunction
endpackage

// File: rtl/stage_watchdog.sv
// stage_watchdog: counts cycles spent in one wait state and flags expiry.
//   clk_i, rst_ni : clock, async active-low reset
//   en_i          : currently in a watched wait state
//   clr_i         : state is changing this cycle; restart the count
//   expired_o     : this is the TIMEOUT-th consecutive cycle in the state
module stage_watchdog
  import ica_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic en_i,
  input  logic clr_i,
  output logic expired_o
);
  localparam int unsigned CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  assign cnt_d = (en_i && !clr_i) ? cnt_q + 1'b1 : '0;
  assign expired_o = en_i && (cnt_q == CW'(TIMEOUT - 1));
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/wprime_iter_ctrl.sv
// wprime_iter_ctrl: sequencer for the fixed-point ICA weight-update loop.
//   start_i/abort_i        : run request / return to IDLE from anywhere
//   load_w_o, br_start_o   : latch w, start branch A (g) and branch B (g')
//   br_a/b_valid_i         : branch results, joined in any order
//   sub_en_o               : capture subtractor output
//   norm_start_o/valid_i   : normaliser handshake
//   conv_start_o/valid_i   : convergence check handshake, conv_ok_i its result
//   commit_w_o             : copy normalised w' into w
//   busy_o, done_o         : run status, end-of-run pulse
//   converged_o, timeout_err_o, iter_count_o : run result
// All outputs are registered and decoded from the next state, so pulses line
// up with the state they belong to without any input-to-output path.
module wprime_iter_ctrl
  import ica_ctrl_pkg::*;
#(
  parameter int unsigned MAX_ITER = MAX_ITER_DEF,
  parameter int unsigned TIMEOUT = TIMEOUT_DEF,
  parameter int unsigned ITER_W = ITER_W_DEF
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic              abort_i,
  output logic              load_w_o,
  output logic              br_start_o,
  input  logic              br_a_valid_i,
  input  logic              br_b_valid_i,
  output logic              sub_en_o,
  output logic              norm_start_o,
  input  logic              norm_valid_i,
  output logic              conv_start_o,
  input  logic              conv_valid_i,
  input  logic              conv_ok_i,
  output logic              commit_w_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              converged_o,
  output logic              timeout_err_o,
  output logic [ITER_W-1:0] iter_count_o
);
  ctrl_state_e state_q, state_d;
  logic fa_q, fa_d, fb_q, fb_d, ok_q, ok_d;
  logic [ITER_W-1:0] iter_q, iter_d;
  logic load_w_q, br_start_q, sub_en_q, norm_start_q, conv_start_q, commit_w_q;
  logic busy_q, done_q, converged_q, timeout_err_q;
  logic br_join, wd_expired, start_run, stay;
  // A valid in the current cycle counts as much as one already remembered.
  assign br_join = (fa_q | br_a_valid_i) & (fb_q | br_b_valid_i);
  assign start_run = (state_q == IDLE) && (state_d == LOAD);
  assign stay = state_d == state_q;
  stage_watchdog #(.TIMEOUT(TIMEOUT)) u_wd (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .en_i     (is_wait_state(state_q)),
    .clr_i    (!stay),
    .expired_o(wd_expired)
  );
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_i) state_d = LOAD;
      LOAD:    state_d = BR_RUN;
      BR_RUN:  state_d = br_join ? SUB : wd_expired ? ERR : BR_RUN;
      SUB:     state_d = NORM;
      NORM:    state_d = norm_valid_i ? CONV : wd_expired ? ERR : NORM;
      CONV:    state_d = conv_valid_i ? COMMIT : wd_expired ? ERR : CONV;
      COMMIT:  state_d = (ok_q || iter_q == ITER_W'(MAX_ITER)) ? DONE : LOAD;
      default: state_d = IDLE;
    endcase
    if (abort_i) state_d = IDLE;
  end
  // Join flags live only while BR_RUN continues; leaving it (join, timeout, abort) clears them.
  assign fa_d = (state_q == BR_RUN) && stay && (fa_q || br_a_valid_i);
  assign fb_d = (state_q == BR_RUN) && stay && (fb_q || br_b_valid_i);
  assign ok_d = start_run ? 1'b0 : (state_q == CONV && conv_valid_i) ? conv_ok_i : ok_q;
  // The count is already incremented while COMMIT decides whether the limit is hit.
  assign iter_d = start_run ? '0 : (state_q == CONV && state_d == COMMIT) ? iter_q + 1'b1 : iter_q;
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      state_q       <= IDLE;
      fa_q          <= 1'b0;
      fb_q          <= 1'b0;
      ok_q          <= 1'b0;
      iter_q        <= '0;
      load_w_q      <= 1'b0;
      br_start_q    <= 1'b0;
      sub_en_q      <= 1'b0;
      norm_start_q  <= 1'b0;
      conv_start_q  <= 1'b0;
      commit_w_q    <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      converged_q   <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      fa_q          <= fa_d;
      fb_q          <= fb_d;
      ok_q          <= ok_d;
      iter_q        <= iter_d;
      load_w_q      <= state_d == LOAD;
      br_start_q    <= state_d == BR_RUN && state_q != BR_RUN;
      sub_en_q      <= state_d == SUB;
      norm_start_q  <= state_d == NORM && state_q != NORM;
      conv_start_q  <= state_d == CONV && state_q != CONV;
      commit_w_q    <= state_d == COMMIT;
      busy_q        <= state_d != IDLE;
      done_q        <= state_d inside {DONE, ERR};
      converged_q   <= start_run ? 1'b0 : converged_q | (state_d == DONE && ok_q);
      timeout_err_q <= start_run ? 1'b0 : timeout_err_q | (state_d == ERR);
    end
  assign load_w_o      = load_w_q;
  assign br_start_o    = br_start_q;
  assign sub_en_o      = sub_en_q;
  assign norm_start_o  = norm_start_q;
  assign conv_start_o  = conv_start_q;
  assign commit_w_o    = commit_w_q;
  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign converged_o   = converged_q;
  assign timeout_err_o = timeout_err_q;
  assign iter_count_o  = iter_q;
endmodule
